// File: rtl/csr_access_unit_if.sv
// Request/response and CSR bus signals of csr_access_unit, grouped as one interface.
// master: the access unit's view; slave: the execute stage plus CSR slave side.
interface csr_access_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_src;
  logic [4:0]        req_zimm;
  logic              req_rs1_zero;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_illegal;

  logic [ADDR_W-1:0] csr_addr;
  logic              csr_re;
  logic              csr_we;
  logic [DATA_W-1:0] csr_wdata;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_ack;

  modport master (
    input  req_valid, req_funct3, req_addr, req_src, req_zimm, req_rs1_zero,
    input  csr_rdata, csr_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal,
    output csr_addr, csr_re, csr_we, csr_wdata
  );

  modport slave (
    output req_valid, req_funct3, req_addr, req_src, req_zimm, req_rs1_zero,
    output csr_rdata, csr_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal,
    input  csr_addr, csr_re, csr_we, csr_wdata
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr access unit: reads a CSR, optionally writes the modified value, returns the old value.
// Optional macro CSR_TIMEOUT_EN bounds each bus phase to TIMEOUT_CYCLES cycles.
module csr_access_unit #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst,
  csr_access_unit_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] operand_q;
  logic              zero_q;
  logic              illegal_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] new_val;
  logic              write_en;
  logic              read_only;
  logic              timeout;

  // RW always writes; RS/RC skip the write when the operand source is x0 / zimm 0.
  assign write_en  = (op_q == 2'b01) || !zero_q;
  assign read_only = (addr_q[ADDR_W-1 -: 2] == 2'b11);

  always_comb begin
    new_val = operand_q;
    case (op_q)
      2'b10:   new_val = bus.csr_rdata | operand_q;
      2'b11:   new_val = bus.csr_rdata & ~operand_q;
      default: new_val = operand_q;
    endcase
  end

`ifdef CSR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (state == READ || state == WRITE) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == READ || state == WRITE) && !bus.csr_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_next = (bus.req_funct3[1:0] == 2'b00) ? RESP : READ;
        end
      end
      READ: begin
        if (bus.csr_ack) begin
          state_next = (write_en && !read_only) ? WRITE : RESP;
        end else if (timeout) begin
          state_next = RESP;
        end
      end
      WRITE: begin
        if (bus.csr_ack || timeout) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; the old value is captured on the read ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_funct3[1:0];
            addr_q    <= bus.req_addr;
            operand_q <= bus.req_funct3[2] ? {{(DATA_W-5){1'b0}}, bus.req_zimm} : bus.req_src;
            zero_q    <= bus.req_funct3[2] ? (bus.req_zimm == 5'd0) : bus.req_rs1_zero;
            illegal_q <= (bus.req_funct3[1:0] == 2'b00);
            rdata_q   <= '0;
          end
        end
        READ: begin
          if (bus.csr_ack) begin
            illegal_q <= write_en && read_only;
            rdata_q   <= (write_en && read_only) ? '0 : bus.csr_rdata;
            wdata_q   <= new_val;
          end else if (timeout) begin
            illegal_q <= 1'b1;
            rdata_q   <= '0;
          end
        end
        WRITE: begin
          if (!bus.csr_ack && timeout) begin
            illegal_q <= 1'b1;
            rdata_q   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.csr_re      = (state == READ);
  assign bus.csr_we      = (state == WRITE);
  assign bus.csr_addr    = addr_q;
  assign bus.csr_wdata   = wdata_q;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_illegal = (state == RESP) && illegal_q;
  assign bus.rsp_rdata   = rdata_q;

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Bus-master side of the CSR interface.
- Accepts one decoded Zicsr instruction from the execute stage (CSRRW/RS/RC and immediate forms).
- Performs the read, then the optional write, against CSR slaves such as the cycle counter.
- Returns the old CSR value for rd, or flags an illegal access.
- Sits between the execute stage and the CSR bus.

Parameters:
- ADDR_W, 12, CSR address width.
- DATA_W, 32, CSR data width.
- TIMEOUT_CYCLES, 15, maximum cycles a bus phase waits for csr_ack; only used with CSR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents a CSR instruction.
- req_ready  out  1  unit idle and able to accept.
- req_funct3  in  3  instruction funct3.
- req_addr  in  ADDR_W  CSR address.
- req_src  in  DATA_W  rs1 value (register forms).
- req_zimm  in  5  immediate (funct3[2]=1 forms).
- req_rs1_zero  in  1  rs1 index is x0 (register forms).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  old CSR value.
- rsp_illegal  out  1  access illegal, valid with rsp_valid.
- csr_addr  out  ADDR_W  bus address.
- csr_re  out  1  bus read strobe.
- csr_we  out  1  bus write strobe.
- csr_wdata  out  DATA_W  bus write data.
- csr_rdata  in  DATA_W  slave read data, valid when csr_ack=1 during a read.
- csr_ack  in  1  slave completion.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1; rsp_valid=0, rsp_illegal=0, rsp_rdata=0; csr_re=0, csr_we=0, csr_addr=0, csr_wdata=0.
- Reset mid-transaction aborts it immediately; strobes drop without waiting for the edge; no response is produced.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch funct3, addr, operand and zero flag.
  - Operand is req_src when funct3[2]=0, else zero-extended req_zimm.
  - Zero flag is req_rs1_zero when funct3[2]=0, else (req_zimm==0).
  - If funct3[1:0]==00 (funct3 000 or 100): go RESP with illegal=1, rsp_rdata=0, no bus activity.
  - Otherwise go READ.
- READ:
  - csr_re=1, csr_addr=latched addr; held until csr_ack sampled high.
  - On ack, capture csr_rdata as old.
  - New value: RW → operand; RS → old | operand; RC → old & ~operand.
  - Write is suppressed for RS/RC when the zero flag is set; RW always writes.
  - Suppressed write → RESP.
  - Write to addr[11:10]==2'b11 (read-only space) → RESP with illegal=1, rsp_rdata=0.
  - Otherwise → WRITE.
- WRITE: csr_we=1, csr_wdata=new value, csr_addr held; on csr_ack → RESP.
- RESP: rsp_valid=1 for exactly one cycle, rsp_rdata=old (0 if illegal); next state IDLE.
- req_ready=0 in all states except IDLE; req_valid outside IDLE is ignored.
- csr_re and csr_we are never high together.
- Latency with single-cycle ack:
  - Request accepted at edge N.
  - READ during N+1, WRITE during N+2, rsp_valid during N+3.
  - Without write: rsp_valid during N+2.
  - Illegal funct3: rsp_valid during N+1.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after RESP.

Optional Feature:
- CSR_TIMEOUT_EN.
- Defined: a counter cleared on entry to READ/WRITE increments each cycle without ack. When it reaches TIMEOUT_CYCLES, drop the strobe and go RESP with illegal=1, rsp_rdata=0. A late ack is then ignored in RESP/IDLE.
- Undefined: no counter; READ/WRITE wait indefinitely for csr_ack.

Test Plan:
- CSRRW (funct3=001), addr=0x340, src=0xDEADBEEF; slave holds 0x12345678, ack 1 cycle → read then write 0xDEADBEEF; rsp_rdata=0x12345678, rsp_illegal=0, rsp_valid 3 cycles after acceptance.
- CSRRS (010), rs1_zero=1, addr=0xC00; counter returns 0x000000A5 → no csr_we; rsp_rdata=0xA5, illegal=0.
- CSRRCI (111), zimm=0x0F; slave holds 0xFF → csr_wdata=0xF0; rsp_rdata=0xFF.
- CSRRW to 0xC00 → read occurs, no csr_we, rsp_illegal=1, rsp_rdata=0. funct3=100 → no strobes, rsp_illegal=1 one cycle after acceptance.
- Slave acks after 4 wait cycles; req_valid held high throughout → csr_re held 5 cycles, req_ready=0, only one transaction issued.
- rst pulsed during WRITE → csr_we=0 immediately, no rsp_valid, req_ready=1. With CSR_TIMEOUT_EN and no ack → illegal response after 15 cycles.
